// File: rtl/matmul_pkg.sv
// Shared types for the matmul result path: lane geometry, FIFO entry layout, parity helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package matmul_pkg;

  localparam int LANES      = 5;
  localparam int LANE_W     = 8;
  localparam int RES_W      = LANES * LANE_W;
  localparam int DROP_CNT_W = 8;

  // One stored result: batch-final tag, aggregate overflow, packed lane data.
  typedef struct packed {
    logic             last;
    logic             ov;
    logic [RES_W-1:0] data;
  } res_entry_t;

  // Even parity per lane byte: each bit makes its lane plus the bit an even count of ones.
  function automatic logic [LANES-1:0] lane_parity(input logic [RES_W-1:0] d);
    logic [LANES-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) begin
      p[i] = ^d[i*LANE_W +: LANE_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/matmul_result_collector_if.sv
// Result-in / host-out bundle of the collector; master = collector side, slave = environment side.
// Latency: n/a (wiring only).
// Backpressure: result side has none; host side is valid/ready. MATMUL_COLL_PARITY_EN adds out_par_o.
interface matmul_result_collector_if #(
  parameter int DEPTH = 8
);
  import matmul_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [RES_W-1:0]      res_data_i;
  logic                  res_val_i;
  logic                  res_ov_i;
  logic                  clr_i;
  logic [RES_W-1:0]      out_data_o;
  logic                  out_ov_o;
  logic                  out_last_o;
  logic                  out_val_o;
  logic                  out_rdy_i;
  logic [CW-1:0]         count_o;
  logic                  full_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;
  logic                  ov_sticky_o;
`ifdef MATMUL_COLL_PARITY_EN
  logic [LANES-1:0]      out_par_o;

  modport master (
    input  res_data_i, res_val_i, res_ov_i, clr_i, out_rdy_i,
    output out_data_o, out_ov_o, out_last_o, out_val_o, count_o, full_o,
           drop_cnt_o, ov_sticky_o, out_par_o
  );
  modport slave (
    output res_data_i, res_val_i, res_ov_i, clr_i, out_rdy_i,
    input  out_data_o, out_ov_o, out_last_o, out_val_o, count_o, full_o,
           drop_cnt_o, ov_sticky_o, out_par_o
  );
`else
  modport master (
    input  res_data_i, res_val_i, res_ov_i, clr_i, out_rdy_i,
    output out_data_o, out_ov_o, out_last_o, out_val_o, count_o, full_o,
           drop_cnt_o, ov_sticky_o
  );
  modport slave (
    output res_data_i, res_val_i, res_ov_i, clr_i, out_rdy_i,
    input  out_data_o, out_ov_o, out_last_o, out_val_o, count_o, full_o,
           drop_cnt_o, ov_sticky_o
  );
`endif

endinterface

// File: rtl/matmul_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count and synchronous clear.
// Latency: write visible at head one cycle after push into empty; head reads 0 when empty.
// Backpressure: none internally; pushes when full are ignored unless a pop frees the slot that cycle.
module matmul_sync_fifo #(
  parameter  int W     = 42,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  // Pointer and occupancy update; clear wins over any traffic in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge CLK) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/matmul_result_collector.sv
// Buffers MAC result pulses in a FWFT FIFO, tags batch-final results, counts drops when full.
// Latency: result appears at the head one cycle after its pulse; no combinational res_* -> out_* path.
// Backpressure: host side valid/ready; upstream has none, so a result arriving to a full FIFO is dropped and counted.
// Build option: MATMUL_COLL_PARITY_EN stores per-lane even parity and presents it on out_par_o.
module matmul_result_collector
  import matmul_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int T     = 10,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int BW    = (T > 1) ? $clog2(T) : 1
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  matmul_result_collector_if.master  bus
);

`ifdef MATMUL_COLL_PARITY_EN
  localparam int FW = $bits(res_entry_t) + LANES;
`else
  localparam int FW = $bits(res_entry_t);
`endif

  logic [BW-1:0]         batch_q, batch_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  ov_sticky_q, ov_sticky_d;

  logic [CW-1:0] count;
  logic          full, empty, pop, push, drop;
  res_entry_t    wr_ent, rd_ent;
  logic [FW-1:0] wr_word, rd_word;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = !empty & bus.out_rdy_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = bus.res_val_i & !bus.clr_i & (!full | pop);
  assign drop  = bus.res_val_i & !bus.clr_i & full & !pop;

  assign wr_ent.last = (batch_q == BW'(T - 1));
  assign wr_ent.ov   = bus.res_ov_i;
  assign wr_ent.data = bus.res_data_i;

`ifdef MATMUL_COLL_PARITY_EN
  assign wr_word       = {lane_parity(bus.res_data_i), wr_ent};
  assign rd_ent        = rd_word[$bits(res_entry_t)-1:0];
  assign bus.out_par_o = rd_word[FW-1 -: LANES];
`else
  assign wr_word = wr_ent;
  assign rd_ent  = rd_word;
`endif

  matmul_sync_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .clr_i   (bus.clr_i),
    .push_i  (push),
    .wdata_i (wr_word),
    .pop_i   (pop),
    .rdata_o (rd_word),
    .count_o (count)
  );

  // Batch framing follows every upstream pulse (accepted or dropped); drop count saturates.
  always_comb begin
    batch_d     = batch_q;
    drop_cnt_d  = drop_cnt_q;
    ov_sticky_d = ov_sticky_q;
    if (bus.clr_i) begin
      batch_d     = '0;
      drop_cnt_d  = '0;
      ov_sticky_d = 1'b0;
    end else begin
      if (bus.res_val_i) begin
        batch_d = (batch_q == BW'(T - 1)) ? '0 : batch_q + BW'(1);
        if (bus.res_ov_i) ov_sticky_d = 1'b1;
      end
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  // Collector bookkeeping registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      batch_q     <= '0;
      drop_cnt_q  <= '0;
      ov_sticky_q <= 1'b0;
    end else begin
      batch_q     <= batch_d;
      drop_cnt_q  <= drop_cnt_d;
      ov_sticky_q <= ov_sticky_d;
    end
  end

  assign bus.out_data_o  = rd_ent.data;
  assign bus.out_ov_o    = rd_ent.ov;
  assign bus.out_last_o  = rd_ent.last;
  assign bus.out_val_o   = !empty;
  assign bus.count_o     = count;
  assign bus.full_o      = full;
  assign bus.drop_cnt_o  = drop_cnt_q;
  assign bus.ov_sticky_o = ov_sticky_q;

endmodule
